// File: rtl/muldiv_arbiter.sv
// Round-robin arbiter sharing one multi-cycle signed multiplier/divider between NREQ clients.
// Optional BUSY watchdog enabled by defining MULDIV_ARB_TIMEOUT_EN.
module muldiv_arbiter #(
    parameter int NREQ           = 4,
    parameter int START_CYCLES   = 1,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*32-1:0]   req_opa,
    input  logic [NREQ*64-1:0]   req_opb,
    input  logic [NREQ-1:0]      req_muordi,
    output logic [NREQ-1:0]      req_ready,
    output logic [NREQ-1:0]      rsp_valid,
    output logic [63:0]          rsp_result,
    output logic                 rsp_error,
    output logic                 busy,
    output logic [2:0]           owner,
    output logic                 mul_start,
    output logic [31:0]          mul_opera1,
    output logic [63:0]          mul_opera2,
    output logic                 mul_muordi,
    input  logic [63:0]          mul_result,
    input  logic                 mul_valid
);

    typedef enum logic [1:0] {IDLE, LAUNCH, BUSY, RESP} state_t;

    state_t             state, state_d;
    logic [1:0]         start_cnt, start_cnt_d;
    logic               valid_q;
    logic [2:0]         rr_ptr;
    logic               grant_vld;
    logic [2:0]         grant_idx;
    logic [NREQ-1:0]    grant_hot;
    logic [NREQ-1:0]    owner_hot;
    logic [31:0]        sel_opa;
    logic [63:0]        sel_opb;
    logic               sel_md;
    logic               done;
    logic               timeout;

    if (NREQ < 2 || NREQ > 8) begin : g_bad_nreq
        $error("muldiv_arbiter: NREQ must be 2..8");
    end
    if (START_CYCLES < 1 || START_CYCLES > 4) begin : g_bad_start
        $error("muldiv_arbiter: START_CYCLES must be 1..4");
    end
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 1023) begin : g_bad_timeout
        $error("muldiv_arbiter: TIMEOUT_CYCLES must be 1..1023");
    end

    // Two-pass search: first the requesters above rr_ptr, then wrap around to 0..rr_ptr.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        grant_hot = '0;
        sel_opa   = '0;
        sel_opb   = '0;
        sel_md    = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (!grant_vld && req_valid[i] && (i > int'(rr_ptr))) begin
                grant_vld = 1'b1;
                grant_idx = 3'(i);
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (!grant_vld && req_valid[i] && (i <= int'(rr_ptr))) begin
                grant_vld = 1'b1;
                grant_idx = 3'(i);
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (grant_idx == 3'(i)) begin
                grant_hot[i] = grant_vld;
                sel_opa      = req_opa[32*i +: 32];
                sel_opb      = req_opb[64*i +: 64];
                sel_md       = req_muordi[i];
            end
        end
    end

    always_comb begin
        owner_hot = '0;
        for (int i = 0; i < NREQ; i++) begin
            owner_hot[i] = (owner == 3'(i));
        end
    end

    // Only a fresh 0->1 of mul_valid completes; a level left high from an earlier op is ignored.
    assign done = (state == BUSY) && mul_valid && !valid_q;

`ifdef MULDIV_ARB_TIMEOUT_EN
    logic [9:0] to_cnt;

    assign timeout = (state == BUSY) && (to_cnt == 10'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            to_cnt <= '0;
        end else if (state != BUSY) begin
            to_cnt <= '0;
        end else if (!timeout) begin
            to_cnt <= to_cnt + 10'd1;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d     = state;
        start_cnt_d = start_cnt;
        case (state)
            IDLE: begin
                if (grant_vld) begin
                    state_d     = LAUNCH;
                    start_cnt_d = '0;
                end
            end
            LAUNCH: begin
                if (start_cnt == 2'(START_CYCLES - 1)) begin
                    state_d = BUSY;
                end else begin
                    start_cnt_d = start_cnt + 2'd1;
                end
            end
            BUSY: begin
                if (done || timeout) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            start_cnt <= '0;
            valid_q   <= 1'b0;
        end else begin
            state     <= state_d;
            start_cnt <= start_cnt_d;
            valid_q   <= mul_valid;
        end
    end

    // Outputs are registered from the next state so they are glitch-free and clear with reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            req_ready  <= '0;
            rsp_valid  <= '0;
            rsp_result <= '0;
            rsp_error  <= 1'b0;
            busy       <= 1'b0;
            owner      <= '0;
            rr_ptr     <= 3'(NREQ - 1);
            mul_start  <= 1'b0;
            mul_opera1 <= '0;
            mul_opera2 <= '0;
            mul_muordi <= 1'b0;
        end else begin
            req_ready <= (state == IDLE) ? grant_hot : '0;
            rsp_valid <= ((state == BUSY) && (state_d == RESP)) ? owner_hot : '0;
            busy      <= (state_d != IDLE);
            mul_start <= (state_d == LAUNCH);
            if ((state == IDLE) && grant_vld) begin
                owner      <= grant_idx;
                rr_ptr     <= grant_idx;
                mul_opera1 <= sel_opa;
                mul_opera2 <= sel_opb;
                mul_muordi <= sel_md;
            end
            if (done) begin
                rsp_result <= mul_result;
                rsp_error  <= 1'b0;
            end else if (timeout) begin
                rsp_result <= '0;
                rsp_error  <= 1'b1;
            end
        end
    end

endmodule
